// File: rtl/dmem_arb_pkg.sv
// Shared types for the DMEM arbiter: port ownership, read-return tags and sizing constants.
package dmem_arb_pkg;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_X = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  localparam int READ_LAT_MAX = 4;
  localparam int WAIT_W       = 8;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the DMEM macro side of the arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_stall;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;

  logic          x_req;
  logic          x_we;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;
  logic          x_gnt;
  logic          x_rvalid;
  logic [DW-1:0] x_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_stall, c_rvalid, c_rdata,
    input  x_req, x_we, x_addr, x_wdata,
    output x_gnt, x_rvalid, x_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_stall, c_rvalid, c_rdata,
    output x_req, x_we, x_addr, x_wdata,
    input  x_gnt, x_rvalid, x_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_rd_tag_pipe.sv
// Read-return tag shift register matching the DMEM read latency; clr drops everything in flight.
module dmem_rd_tag_pipe
  import dmem_arb_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic gclk,
  input  logic clr,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t [STAGES-1:0] vld_pipe;

  always_ff @(posedge gclk) begin
    if (clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= tag_in;
      for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign tag_out = vld_pipe[STAGES-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port DMEM arbiter: core (C) vs loader/debug (X), one access per cycle,
// read data routed back to its owner after the fixed RAM read latency.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int READ_LAT      = 1,
  parameter int CORE_PRIORITY = 0,
  parameter int MAX_WAIT      = 8
) (
  input logic           CLK,
  input logic           RESET,
  dmem_arbiter_if.slave bus
);

  localparam int LAT = (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX :
                       (READ_LAT < 1)            ? 1 : READ_LAT;

  owner_e            last_owner;
  logic [WAIT_W-1:0] wait_cnt;
  logic              starved;
  logic              c_win, x_win;
  logic              c_rv, x_rv;
  logic [AW-1:0]     addr_mux;
  logic [DW-1:0]     c_rdata_q, x_rdata_q;
  tag_t              tag_in, tag_out;

  assign starved = (wait_cnt == WAIT_W'(MAX_WAIT));

  // Grants are suppressed during reset so nothing new enters the RAM or tag pipe.
  always_comb begin
    c_win = 1'b0;
    x_win = 1'b0;
    if (!RESET) begin
      if (bus.c_req && bus.x_req) begin
        if (CORE_PRIORITY != 0) x_win = starved;
        else                    x_win = (last_owner == OWN_C);
        c_win = !x_win;
      end else begin
        c_win = bus.c_req;
        x_win = bus.x_req;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_owner <= OWN_X;
      wait_cnt   <= '0;
      c_rdata_q  <= '0;
      x_rdata_q  <= '0;
    end else begin
      if (c_win)      last_owner <= OWN_C;
      else if (x_win) last_owner <= OWN_X;
      if (!bus.x_req || x_win) wait_cnt <= '0;
      else if (!starved)        wait_cnt <= wait_cnt + WAIT_W'(1);
      if (c_rv) c_rdata_q <= bus.mem_rdata;
      if (x_rv) x_rdata_q <= bus.mem_rdata;
    end
  end

  assign addr_mux      = x_win ? bus.x_addr : bus.c_addr;
  assign bus.mem_en    = c_win | x_win;
  assign bus.mem_we    = (c_win & bus.c_we) | (x_win & bus.x_we);
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = x_win ? bus.x_wdata : bus.c_wdata;

  assign tag_in.valid = bus.mem_en & ~bus.mem_we;
  assign tag_in.owner = x_win ? OWN_X : OWN_C;

  dmem_rd_tag_pipe #(.STAGES(LAT)) u_tag_pipe (
    .gclk    (CLK),
    .clr     (RESET),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign c_rv = tag_out.valid & (tag_out.owner == OWN_C) & ~RESET;
  assign x_rv = tag_out.valid & (tag_out.owner == OWN_X) & ~RESET;

  assign bus.c_gnt    = c_win;
  assign bus.x_gnt    = x_win;
  assign bus.c_stall  = bus.c_req & ~c_win;
  assign bus.c_rvalid = c_rv;
  assign bus.x_rvalid = x_rv;
  // Returning data is visible in its valid cycle; otherwise the last value is held.
  assign bus.c_rdata  = c_rv ? bus.mem_rdata : c_rdata_q;
  assign bus.x_rdata  = x_rv ? bus.mem_rdata : x_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: round-robin table on a READ_LAT=1 arbiter, plus fixed-priority
// and reset-mid-flight (READ_LAT=3) sequences on two more instances.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus_rr  ();
  dmem_arbiter_if #(.AW(32), .DW(32)) bus_fp  ();
  dmem_arbiter_if #(.AW(32), .DW(32)) bus_rl3 ();

  dmem_arbiter #(.READ_LAT(1), .CORE_PRIORITY(0)) u_rr (
    .CLK(clk), .RESET(rst), .bus(bus_rr));
  dmem_arbiter #(.READ_LAT(1), .CORE_PRIORITY(1), .MAX_WAIT(3)) u_fp (
    .CLK(clk), .RESET(rst), .bus(bus_fp));
  dmem_arbiter #(.READ_LAT(3), .CORE_PRIORITY(0)) u_rl3 (
    .CLK(clk), .RESET(rst), .bus(bus_rl3));

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'hA50000, a};
  endfunction

  // DMEM models: unwritten locations hold init_val; idle cycles return junk.
  logic [31:0] ram_rr [256], ram_fp [256], ram_rl3 [256];
  bit          wr_rr  [256], wr_fp  [256], wr_rl3  [256];
  logic [31:0] rd_rr, rd_fp, rd0_rl3, rd1_rl3, rd2_rl3;

  always @(posedge clk) begin
    if (bus_rr.mem_en && bus_rr.mem_we) begin
      ram_rr[bus_rr.mem_addr[7:0]] <= bus_rr.mem_wdata;
      wr_rr[bus_rr.mem_addr[7:0]]  <= 1'b1;
    end
    rd_rr <= (bus_rr.mem_en && !bus_rr.mem_we) ?
             (wr_rr[bus_rr.mem_addr[7:0]] ? ram_rr[bus_rr.mem_addr[7:0]] : init_val(bus_rr.mem_addr[7:0]))
             : 32'hBAD00000;
  end

  always @(posedge clk) begin
    if (bus_fp.mem_en && bus_fp.mem_we) begin
      ram_fp[bus_fp.mem_addr[7:0]] <= bus_fp.mem_wdata;
      wr_fp[bus_fp.mem_addr[7:0]]  <= 1'b1;
    end
    rd_fp <= (bus_fp.mem_en && !bus_fp.mem_we) ?
             (wr_fp[bus_fp.mem_addr[7:0]] ? ram_fp[bus_fp.mem_addr[7:0]] : init_val(bus_fp.mem_addr[7:0]))
             : 32'hBAD00000;
  end

  always @(posedge clk) begin
    if (bus_rl3.mem_en && bus_rl3.mem_we) begin
      ram_rl3[bus_rl3.mem_addr[7:0]] <= bus_rl3.mem_wdata;
      wr_rl3[bus_rl3.mem_addr[7:0]]  <= 1'b1;
    end
    rd0_rl3 <= (bus_rl3.mem_en && !bus_rl3.mem_we) ?
               (wr_rl3[bus_rl3.mem_addr[7:0]] ? ram_rl3[bus_rl3.mem_addr[7:0]] : init_val(bus_rl3.mem_addr[7:0]))
               : 32'hBAD00000;
    rd1_rl3 <= rd0_rl3;
    rd2_rl3 <= rd1_rl3;
  end

  assign bus_rr.mem_rdata  = rd_rr;
  assign bus_fp.mem_rdata  = rd_fp;
  assign bus_rl3.mem_rdata = rd2_rl3;

  typedef struct {
    logic        cr, cw;
    logic [7:0]  ca;
    logic [31:0] cd;
    logic        xr, xw;
    logic [7:0]  xa;
    logic [31:0] xd;
    logic        e_cg, e_xg, e_st, e_en, e_we, e_crv, e_xrv;
    logic [31:0] e_crd, e_xrd;
    logic [7:0]  e_ma;
  } vec_t;

  vec_t vt [14];

  function automatic vec_t mk(
    input logic cr, cw, input logic [7:0] ca, input logic [31:0] cd,
    input logic xr, xw, input logic [7:0] xa, input logic [31:0] xd,
    input logic cg, xg, st, en, we, crv, xrv,
    input logic [31:0] crd, xrd, input logic [7:0] ma);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.xr = xr; v.xw = xw; v.xa = xa; v.xd = xd;
    v.e_cg = cg; v.e_xg = xg; v.e_st = st; v.e_en = en; v.e_we = we;
    v.e_crv = crv; v.e_xrv = xrv; v.e_crd = crd; v.e_xrd = xrd; v.e_ma = ma;
    return v;
  endfunction

  task automatic set_in(input logic cr, cw, input logic [7:0] ca, input logic [31:0] cd,
                        input logic xr, xw, input logic [7:0] xa, input logic [31:0] xd);
    bus_rr.c_req  = cr; bus_rr.c_we  = cw; bus_rr.c_addr  = {24'h0, ca}; bus_rr.c_wdata  = cd;
    bus_rr.x_req  = xr; bus_rr.x_we  = xw; bus_rr.x_addr  = {24'h0, xa}; bus_rr.x_wdata  = xd;
    bus_fp.c_req  = cr; bus_fp.c_we  = cw; bus_fp.c_addr  = {24'h0, ca}; bus_fp.c_wdata  = cd;
    bus_fp.x_req  = xr; bus_fp.x_we  = xw; bus_fp.x_addr  = {24'h0, xa}; bus_fp.x_wdata  = xd;
    bus_rl3.c_req = cr; bus_rl3.c_we = cw; bus_rl3.c_addr = {24'h0, ca}; bus_rl3.c_wdata = cd;
    bus_rl3.x_req = xr; bus_rl3.x_we = xw; bus_rl3.x_addr = {24'h0, xa}; bus_rl3.x_wdata = xd;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  logic [7:0] fp_cg;

  initial begin
    //            cr cw ca     cd            xr xw xa     xd            cg xg st en we crv xrv crd           xrd           ma
    vt[0]  = mk(1, 0, 8'h10, 32'h0,        0, 0, 8'h00, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        8'h10);
    vt[1]  = mk(0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0,        8'h00);
    vt[2]  = mk(0, 0, 8'h00, 32'h0,        1, 0, 8'h05, 32'h0,        0, 1, 0, 1, 0, 0, 0, 32'hDEADBEEF, 32'h0,        8'h05);
    vt[3]  = mk(1, 0, 8'h20, 32'h0,        1, 0, 8'h30, 32'h0,        1, 0, 0, 1, 0, 0, 1, 32'hDEADBEEF, 32'hA5000005, 8'h20);
    vt[4]  = mk(1, 0, 8'h21, 32'h0,        1, 0, 8'h30, 32'h0,        0, 1, 1, 1, 0, 1, 0, 32'hA5000020, 32'hA5000005, 8'h30);
    vt[5]  = mk(1, 0, 8'h21, 32'h0,        1, 0, 8'h31, 32'h0,        1, 0, 0, 1, 0, 0, 1, 32'hA5000020, 32'hA5000030, 8'h21);
    vt[6]  = mk(1, 0, 8'h22, 32'h0,        1, 0, 8'h31, 32'h0,        0, 1, 1, 1, 0, 1, 0, 32'hA5000021, 32'hA5000030, 8'h31);
    vt[7]  = mk(1, 0, 8'h22, 32'h0,        0, 0, 8'h00, 32'h0,        1, 0, 0, 1, 0, 0, 1, 32'hA5000021, 32'hA5000031, 8'h22);
    vt[8]  = mk(0, 0, 8'h00, 32'h0,        1, 1, 8'h40, 32'h0000CAFE, 0, 1, 0, 1, 1, 1, 0, 32'hA5000022, 32'hA5000031, 8'h40);
    vt[9]  = mk(1, 0, 8'h40, 32'h0,        0, 0, 8'h00, 32'h0,        1, 0, 0, 1, 0, 0, 0, 32'hA5000022, 32'hA5000031, 8'h40);
    vt[10] = mk(1, 0, 8'h11, 32'h0,        1, 0, 8'h12, 32'h0,        0, 1, 1, 1, 0, 1, 0, 32'h0000CAFE, 32'hA5000031, 8'h12);
    vt[11] = mk(1, 0, 8'h11, 32'h0,        1, 0, 8'h13, 32'h0,        1, 0, 0, 1, 0, 0, 1, 32'h0000CAFE, 32'hA5000012, 8'h11);
    vt[12] = mk(0, 0, 8'h00, 32'h0,        1, 0, 8'h13, 32'h0,        0, 1, 0, 1, 0, 1, 0, 32'hA5000011, 32'hA5000012, 8'h13);
    vt[13] = mk(0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        0, 0, 0, 0, 0, 0, 1, 32'hA5000011, 32'hA5000013, 8'h00);

    // Reset with both ports requesting: nothing may be granted.
    rst = 1'b1; idle(); tick();
    set_in(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0); #2;
    chk1("rst c_gnt", bus_rr.c_gnt, 1'b0);
    chk1("rst x_gnt", bus_rr.x_gnt, 1'b0);
    chk1("rst mem_en", bus_rr.mem_en, 1'b0);
    chk1("rst mem_we", bus_rr.mem_we, 1'b0);
    chk1("rst c_rvalid", bus_rr.c_rvalid, 1'b0);
    chk1("rst x_rvalid", bus_rr.x_rvalid, 1'b0);
    chk32("rst c_rdata", bus_rr.c_rdata, 32'h0);
    chk32("rst x_rdata", bus_rr.x_rdata, 32'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      set_in(vt[i].cr, vt[i].cw, vt[i].ca, vt[i].cd, vt[i].xr, vt[i].xw, vt[i].xa, vt[i].xd);
      #2;
      chk1($sformatf("v%0d c_gnt", i), bus_rr.c_gnt, vt[i].e_cg);
      chk1($sformatf("v%0d x_gnt", i), bus_rr.x_gnt, vt[i].e_xg);
      chk1($sformatf("v%0d c_stall", i), bus_rr.c_stall, vt[i].e_st);
      chk1($sformatf("v%0d mem_en", i), bus_rr.mem_en, vt[i].e_en);
      chk1($sformatf("v%0d mem_we", i), bus_rr.mem_we, vt[i].e_we);
      chk1($sformatf("v%0d c_rvalid", i), bus_rr.c_rvalid, vt[i].e_crv);
      chk1($sformatf("v%0d x_rvalid", i), bus_rr.x_rvalid, vt[i].e_xrv);
      chk32($sformatf("v%0d c_rdata", i), bus_rr.c_rdata, vt[i].e_crd);
      chk32($sformatf("v%0d x_rdata", i), bus_rr.x_rdata, vt[i].e_xrd);
      if (vt[i].e_en) begin
        chk32($sformatf("v%0d mem_addr", i), bus_rr.mem_addr, {24'h0, vt[i].e_ma});
        if (vt[i].e_we) chk32($sformatf("v%0d mem_wdata", i), bus_rr.mem_wdata, vt[i].xd);
      end
      tick();
    end

    // Fixed priority, MAX_WAIT=3: X is forced in every fourth cycle of a sustained tie.
    idle(); rst = 1'b1; tick();
    rst = 1'b0;
    fp_cg = 8'b0111_0111;
    for (int k = 0; k < 8; k++) begin
      set_in(1'b1, 1'b0, 8'h50, 32'h0, 1'b1, 1'b0, 8'h60, 32'h0); #2;
      chk1($sformatf("fp%0d c_gnt", k), bus_fp.c_gnt, fp_cg[k]);
      chk1($sformatf("fp%0d x_gnt", k), bus_fp.x_gnt, ~fp_cg[k]);
      chk1($sformatf("fp%0d c_stall", k), bus_fp.c_stall, ~fp_cg[k]);
      if (k == 1) begin
        chk1("fp1 c_rvalid", bus_fp.c_rvalid, 1'b1);
        chk32("fp1 c_rdata", bus_fp.c_rdata, 32'hA5000050);
      end
      if (k == 4) begin
        chk1("fp4 x_rvalid", bus_fp.x_rvalid, 1'b1);
        chk32("fp4 x_rdata", bus_fp.x_rdata, 32'hA5000060);
      end
      tick();
    end

    // READ_LAT=3: a read granted just before reset must never return.
    idle(); rst = 1'b1; tick();
    rst = 1'b0;
    set_in(1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 1'b0, 8'h00, 32'h0); #2;
    chk1("rl3 pre c_gnt", bus_rl3.c_gnt, 1'b1);
    tick();
    rst = 1'b1;
    set_in(1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 1'b0, 8'h20, 32'h0); #2;
    chk1("rl3 rst c_gnt", bus_rl3.c_gnt, 1'b0);
    chk1("rl3 rst x_gnt", bus_rl3.x_gnt, 1'b0);
    chk1("rl3 rst mem_en", bus_rl3.mem_en, 1'b0);
    chk1("rl3 rst mem_we", bus_rl3.mem_we, 1'b0);
    chk1("rl3 rst c_rvalid", bus_rl3.c_rvalid, 1'b0);
    chk1("rl3 rst x_rvalid", bus_rl3.x_rvalid, 1'b0);
    tick();
    rst = 1'b0; idle();
    for (int k = 0; k < 5; k++) begin
      #2;
      chk1($sformatf("rl3 drop%0d c_rvalid", k), bus_rl3.c_rvalid, 1'b0);
      chk32($sformatf("rl3 drop%0d c_rdata", k), bus_rl3.c_rdata, 32'h0);
      tick();
    end
    set_in(1'b1, 1'b0, 8'h22, 32'h0, 1'b1, 1'b0, 8'h33, 32'h0); #2;
    chk1("rl3 tie c_gnt", bus_rl3.c_gnt, 1'b1);
    chk1("rl3 tie x_gnt", bus_rl3.x_gnt, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 8'h33, 32'h0); #2;
    chk1("rl3 x_gnt", bus_rl3.x_gnt, 1'b1);
    tick();
    idle(); #2;
    chk1("rl3 lat2 c_rvalid", bus_rl3.c_rvalid, 1'b0);
    tick(); #2;
    chk1("rl3 lat3 c_rvalid", bus_rl3.c_rvalid, 1'b1);
    chk32("rl3 lat3 c_rdata", bus_rl3.c_rdata, 32'hA5000022);
    chk1("rl3 lat3 x_rvalid", bus_rl3.x_rvalid, 1'b0);
    tick(); #2;
    chk1("rl3 x_rvalid", bus_rl3.x_rvalid, 1'b1);
    chk32("rl3 x_rdata", bus_rl3.x_rdata, 32'hA5000033);
    chk1("rl3 c_rvalid off", bus_rl3.c_rvalid, 1'b0);
    chk32("rl3 c_rdata hold", bus_rl3.c_rdata, 32'hA5000022);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
